// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_rd_pkg
// Brief   : Shared types, sizes and index helpers for the FIFO read controller
// Revision: 1.0  initial release
// ============================================================================
package fifo_rd_pkg;

  typedef enum logic [0:0] {
    STREAM = 1'b0,
    FLUSH  = 1'b1
  } rd_state_e;

  localparam int BUF_DEPTH  = 3;
  localparam int RD_LATENCY = 1;
  localparam int CNT_W      = $clog2(BUF_DEPTH + 1);
  localparam int IDX_W      = $clog2(BUF_DEPTH);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(BUF_DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

  // A read may only be issued if its word is guaranteed a slot on arrival.
  function automatic logic has_credit(input logic [CNT_W-1:0] cnt, input logic inflight);
    return ((CNT_W+1)'(cnt) + (CNT_W+1)'(inflight)) < (CNT_W+1)'(BUF_DEPTH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_read_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : fifo_read_ctrl_if
// Brief   : FIFO read port plus valid/ready output stream of the read controller
// Revision: 1.0  initial release
// ============================================================================
interface fifo_read_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_buf.sv
`default_nettype none
// ============================================================================
// Module  : fifo_rd_buf
// Brief   : 3-entry circular register buffer with push/pop/clear and fill count
// Revision: 1.0  initial release
// ============================================================================
module fifo_rd_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  clear,
  input  wire logic                  push,
  input  wire logic                  pop,
  input  wire logic [DATA_WIDTH-1:0] din,
  output logic      [DATA_WIDTH-1:0] dout,
  output logic      [CNT_W-1:0]      cnt
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [IDX_W-1:0]      r_head;
  logic [IDX_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else if (clear) begin
      // Storage is left as-is; only the pointers forget it.
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (push) begin
        r_mem[r_tail] <= din;
        r_tail        <= next_idx(r_tail);
      end
      if (pop) r_head <= next_idx(r_head);
      case ({push, pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign dout = r_mem[r_head];
  assign cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/fifo_read_ctrl_sva.sv
`default_nettype none
// ============================================================================
// Module  : fifo_read_ctrl_sva
// Brief   : Protocol and overflow properties of the FIFO read controller
// Revision: 1.0  initial release
// ============================================================================
module fifo_read_ctrl_sva
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input wire logic                  clk,
  input wire logic                  rst_n,
  input wire logic                  m_valid,
  input wire logic                  m_ready,
  input wire logic [DATA_WIDTH-1:0] m_data,
  input wire logic                  flush,
  input wire logic                  push,
  input wire logic [CNT_W-1:0]      cnt,
  input wire logic                  inflight
);

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (cnt < CNT_W'(BUF_DEPTH)));

  a_credit : assert property (@(posedge clk) disable iff (!rst_n)
    ((CNT_W+1)'(cnt) + (CNT_W+1)'(inflight)) <= (CNT_W+1)'(BUF_DEPTH));

  // A stalled word stays put unless a flush deliberately discards it.
  a_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (m_valid && !m_ready && !flush) |=> (m_valid && $stable(m_data)));

endmodule
`default_nettype wire

// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fifo_read_ctrl
// Brief   : FIFO read-side master; hides 1-cycle read latency behind a 3-word buffer
// Revision: 1.0  initial release
// ============================================================================
module fifo_read_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  fifo_read_ctrl_if.master          bus,
  input  wire logic                 flush,
  output logic      [CNT_WIDTH-1:0] word_cnt,
  output logic                      busy
);

  rd_state_e             r_state;
  rd_state_e             w_state_nxt;
  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_word_cnt;
  logic [CNT_W-1:0]      w_cnt;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_rd_en;
  logic                  w_clear;
  logic                  w_push;
  logic                  w_valid;
  logic                  w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= STREAM;
    else        r_state <= w_state_nxt;
  end

  // rd_en sees only registers, fifo_empty and flush, never m_ready.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_clear     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      STREAM: begin
        w_push = r_inflight && !flush;
        if (flush) begin
          w_clear = 1'b1;
          if (r_inflight) w_state_nxt = FLUSH;
        end else begin
          w_rd_en = rst_n && !bus.fifo_empty && has_credit(w_cnt, r_inflight);
        end
      end
      FLUSH:   w_state_nxt = STREAM;
      default: w_state_nxt = STREAM;
    endcase
  end

  assign w_valid = (w_cnt != '0) && (r_state == STREAM);
  assign w_pop   = w_valid && bus.m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_pop) r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
    end
  end

  fifo_rd_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .push  (w_push),
    .pop   (w_pop && !w_clear),
    .din   (bus.fifo_dout),
    .dout  (w_head),
    .cnt   (w_cnt)
  );

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = w_head;
  assign word_cnt       = r_word_cnt;
  assign busy           = (w_cnt != '0) || r_inflight || (r_state == FLUSH);

  fifo_read_ctrl_sva #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sva (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_valid  (w_valid),
    .m_ready  (bus.m_ready),
    .m_data   (w_head),
    .flush    (flush),
    .push     (w_push),
    .cnt      (w_cnt),
    .inflight (r_inflight)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_read_ctrl
// Brief   : Directed cycle vectors plus streaming and counter-wrap sequences
// Revision: 1.0  initial release
// ============================================================================
module tb_fifo_read_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] word_cnt;
  logic        busy;
  logic [3:0]  word_cnt_w;
  logic        busy_w;

  int checks = 0;
  int errors = 0;

  fifo_read_ctrl_if #(.DATA_WIDTH(16)) bus ();
  fifo_read_ctrl_if #(.DATA_WIDTH(16)) bus_w ();

  // Narrow-counter copy sees exactly the same stimulus as the main instance.
  assign bus_w.fifo_empty = bus.fifo_empty;
  assign bus_w.fifo_dout  = bus.fifo_dout;
  assign bus_w.m_ready    = bus.m_ready;

  fifo_read_ctrl #(.DATA_WIDTH(16), .CNT_WIDTH(16)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .flush    (flush),
    .word_cnt (word_cnt),
    .busy     (busy)
  );

  fifo_read_ctrl #(.DATA_WIDTH(16), .CNT_WIDTH(4)) u_dut_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_w),
    .flush    (flush),
    .word_cnt (word_cnt_w),
    .busy     (busy_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        empty;
    logic [15:0] dout;
    logic        ready;
    logic        flush;
    logic        e_rd;
    logic        e_valid;
    logic [15:0] e_data;
    logic [15:0] e_wc;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [15:0] d, input logic rdy,
                     input logic f, input logic xrd, input logic xv, input logic [15:0] xd,
                     input logic [15:0] xwc, input logic xb);
    vec_t v;
    v.rst_n = r;   v.empty = e;    v.dout = d;    v.ready = rdy; v.flush = f;
    v.e_rd  = xrd; v.e_valid = xv; v.e_data = xd; v.e_wc = xwc;  v.e_busy = xb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = '0;
    bus.m_ready    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  int issued;
  int seen;
  int first_v;
  int last_v;
  logic        prev_rd;
  logic [15:0] pend;

  initial begin
    //    rst emp dout      rdy fl | rd  v  data      wc  busy
    add(1, 0, 16'h0000, 1, 0,  1, 0, 16'h0000, 0, 0);   // latency: read issued
    add(1, 1, 16'hA5A5, 1, 0,  0, 0, 16'h0000, 0, 1);
    add(1, 1, 16'hA5A5, 1, 0,  0, 1, 16'hA5A5, 0, 1);   // valid two cycles later
    add(1, 1, 16'hA5A5, 1, 0,  0, 0, 16'h0000, 1, 0);
    add(1, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 1, 0);   // backpressure
    add(1, 0, 16'h0101, 0, 0,  1, 0, 16'h0000, 1, 1);
    add(1, 0, 16'h0202, 0, 0,  1, 1, 16'h0101, 1, 1);
    add(1, 0, 16'h0303, 0, 0,  0, 1, 16'h0101, 1, 1);   // credit exhausted
    add(1, 0, 16'h0303, 0, 0,  0, 1, 16'h0101, 1, 1);
    add(1, 0, 16'h0303, 0, 0,  0, 1, 16'h0101, 1, 1);
    add(1, 0, 16'h0303, 1, 0,  0, 1, 16'h0101, 1, 1);   // release
    add(1, 0, 16'h0303, 1, 0,  1, 1, 16'h0202, 2, 1);
    add(1, 1, 16'h0404, 1, 0,  0, 1, 16'h0303, 3, 1);   // capture + pop together
    add(1, 1, 16'h0404, 1, 0,  0, 1, 16'h0404, 4, 1);
    add(1, 1, 16'h0404, 1, 0,  0, 0, 16'h0202, 5, 0);
    add(1, 0, 16'h0000, 0, 0,  1, 0, 16'h0202, 5, 0);   // flush with inflight, cnt=2
    add(1, 0, 16'h1111, 0, 0,  1, 0, 16'h0202, 5, 1);
    add(1, 0, 16'h2222, 0, 0,  1, 1, 16'h1111, 5, 1);
    add(1, 0, 16'h3333, 1, 1,  0, 1, 16'h1111, 5, 1);   // pop coincides with flush
    add(1, 0, 16'h3333, 1, 1,  0, 0, 16'h2222, 6, 1);   // FLUSH state ignores flush
    add(1, 0, 16'h3333, 1, 0,  1, 0, 16'h2222, 6, 0);
    add(1, 1, 16'h4444, 1, 0,  0, 0, 16'h2222, 6, 1);
    add(1, 1, 16'h4444, 1, 0,  0, 1, 16'h4444, 6, 1);   // next FIFO entry, 3333 dropped
    add(1, 1, 16'h4444, 1, 0,  0, 0, 16'h0404, 7, 0);
    add(1, 0, 16'h0000, 0, 0,  1, 0, 16'h0404, 7, 0);   // flush without inflight
    add(1, 1, 16'h5555, 0, 0,  0, 0, 16'h0404, 7, 1);
    add(1, 1, 16'h5555, 0, 1,  0, 1, 16'h5555, 7, 1);
    add(1, 0, 16'h0000, 0, 0,  1, 0, 16'h4444, 7, 0);   // still STREAM: reads at once
    add(1, 0, 16'h6666, 0, 0,  1, 0, 16'h4444, 7, 1);
    add(1, 0, 16'h7777, 0, 0,  1, 1, 16'h6666, 7, 1);
    add(0, 0, 16'h8888, 0, 0,  0, 1, 16'h6666, 7, 1);   // reset with cnt=2, inflight=1
    add(1, 1, 16'h8888, 1, 0,  0, 0, 16'h0000, 0, 0);
    add(1, 1, 16'h8888, 1, 0,  0, 0, 16'h0000, 0, 0);   // dropped word never shows

    do_reset();
    chk("rst_rd_en", 0, bus.fifo_rd_en, 0);
    chk("rst_valid", 0, bus.m_valid, 0);
    chk("rst_data",  0, bus.m_data, 0);
    chk("rst_wc",    0, word_cnt, 0);
    chk("rst_busy",  0, busy, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n          = vecs[i].rst_n;
      bus.fifo_empty = vecs[i].empty;
      bus.fifo_dout  = vecs[i].dout;
      bus.m_ready    = vecs[i].ready;
      flush          = vecs[i].flush;
      #1;
      chk("rd_en",    i, bus.fifo_rd_en, vecs[i].e_rd);
      chk("m_valid",  i, bus.m_valid,    vecs[i].e_valid);
      chk("m_data",   i, bus.m_data,     vecs[i].e_data);
      chk("word_cnt", i, word_cnt,       vecs[i].e_wc);
      chk("busy",     i, busy,           vecs[i].e_busy);
    end

    // Streaming: 100 words 0..99 behind a FIFO that answers one cycle after rd_en.
    do_reset();
    rst_n       = 1'b1;
    bus.m_ready = 1'b1;
    issued  = 0;
    seen    = 0;
    first_v = -1;
    last_v  = -1;
    prev_rd = 1'b0;
    pend    = '0;
    for (int cyc = 0; cyc < 130; cyc++) begin
      @(negedge clk);
      if (prev_rd) bus.fifo_dout = pend;
      bus.fifo_empty = (issued >= 100);
      #1;
      if (seen == 16 && bus.m_valid) chk("wrap_16", seen, word_cnt_w, 0);
      if (seen == 17 && bus.m_valid) chk("wrap_17", seen, word_cnt_w, 1);
      if (bus.m_valid) begin
        chk("tp_data", seen, bus.m_data, seen);
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        seen++;
      end
      prev_rd = bus.fifo_rd_en;
      if (prev_rd) begin
        pend = 16'(issued);
        issued++;
      end
    end
    chk("tp_first_valid", 0, first_v, 2);
    chk("tp_last_valid",  0, last_v, 101);
    chk("tp_words",       0, seen, 100);
    chk("tp_reads",       0, issued, 100);
    chk("tp_word_cnt",    0, word_cnt, 100);
    chk("tp_wrap_final",  0, word_cnt_w, 4);
    chk("tp_busy_idle",   0, busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
